// File: rtl/bht_update_sched.sv
// BHT update sequencer: clears the table after reset/INV_ALL, queues resolved branches and applies them as read-modify-writes.
// Optional performance counters are built only when BHT_PERF_CNT_EN is defined.
module bht_update_sched #(
    parameter int ADDR_WIDTH    = 39,
    parameter int HISTORY_DEPTH = 512,
    parameter int FIFO_DEPTH    = 4,
    localparam int H     = $clog2(HISTORY_DEPTH),
    localparam int TAG_W = ADDR_WIDTH - H - 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  PIPE_READY,
    input  logic                  INV_ALL,
    input  logic                  UPD_VALID,
    output logic                  UPD_READY,
    input  logic [ADDR_WIDTH-1:0] UPD_PC,
    input  logic [ADDR_WIDTH-1:0] UPD_TARGET,
    input  logic                  UPD_TAKEN,
    input  logic                  UPD_RETURN,
    input  logic                  UPD_MISPRED,
    output logic [H-1:0]          TBL_RD_IDX,
    input  logic                  TBL_RD_STATE,
    input  logic                  TBL_RD_RETURN,
    input  logic [TAG_W-1:0]      TBL_RD_TAG,
    input  logic [ADDR_WIDTH-1:0] TBL_RD_TARGET,
    input  logic [1:0]            TBL_RD_HIST,
    output logic                  TBL_WE,
    output logic [H-1:0]          TBL_WR_IDX,
    output logic                  TBL_WR_STATE,
    output logic                  TBL_WR_RETURN,
    output logic [TAG_W-1:0]      TBL_WR_TAG,
    output logic [ADDR_WIDTH-1:0] TBL_WR_TARGET,
    output logic [1:0]            TBL_WR_HIST,
    output logic                  INIT_BUSY,
    output logic [31:0]           BRANCH_CNT,
    output logic [31:0]           MISPRED_CNT
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic {INIT, RUN} state_t;

    state_t          state, next_state;
    logic [H-1:0]    sweep, next_sweep;
    logic [PW-1:0]   head, tail;
    logic [PW:0]     count, next_count;
    logic            upd_ready_q, next_ready;
    logic            push, pop, hit;

    // PC bits [1:0] carry no index or tag information, so they are not stored
    logic [ADDR_WIDTH-3:0] fifo_pc     [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_target [FIFO_DEPTH];
    logic                  fifo_taken  [FIFO_DEPTH];
    logic                  fifo_ret    [FIFO_DEPTH];

    logic [ADDR_WIDTH-3:0] head_pc;
    logic [H-1:0]          head_idx;
    logic [TAG_W-1:0]      head_tag;
    logic [ADDR_WIDTH-1:0] head_target;
    logic                  head_taken;

    function automatic logic [1:0] train_hist(input logic [1:0] h, input logic taken);
        if (taken)
            return (h == 2'b00) ? 2'b01 : 2'b11;
        else
            return (h == 2'b00) ? 2'b00 : h - 2'b01;
    endfunction

    assign head_pc     = fifo_pc[head];
    assign head_idx    = head_pc[H-1:0];
    assign head_tag    = head_pc[ADDR_WIDTH-3:H];
    assign head_target = fifo_target[head];
    assign head_taken  = fifo_taken[head];

    assign push = UPD_VALID && upd_ready_q && (state == RUN) && !INV_ALL;
    assign pop  = (state == RUN) && (count != '0) && PIPE_READY && !INV_ALL;
    assign hit  = TBL_RD_STATE && (TBL_RD_TAG == head_tag) &&
                  ((TBL_RD_TARGET == head_target) || !head_taken);

    assign TBL_RD_IDX = head_idx;
    assign UPD_READY  = upd_ready_q;
    assign INIT_BUSY  = (state == INIT);

    always_comb begin
        next_state    = state;
        next_sweep    = sweep;
        TBL_WE        = 1'b0;
        TBL_WR_IDX    = head_idx;
        TBL_WR_STATE  = 1'b0;
        TBL_WR_RETURN = 1'b0;
        TBL_WR_TAG    = '0;
        TBL_WR_TARGET = '0;
        TBL_WR_HIST   = 2'b01;
        case (state)
            INIT: begin
                TBL_WE     = 1'b1;
                TBL_WR_IDX = sweep;
                next_sweep = sweep + 1'b1;
                if (sweep == {H{1'b1}})
                    next_state = RUN;
            end
            RUN: begin
                if (pop && hit) begin
                    TBL_WE        = 1'b1;
                    TBL_WR_STATE  = TBL_RD_STATE;
                    TBL_WR_RETURN = TBL_RD_RETURN;
                    TBL_WR_TAG    = TBL_RD_TAG;
                    TBL_WR_TARGET = TBL_RD_TARGET;
                    TBL_WR_HIST   = train_hist(TBL_RD_HIST, head_taken);
                end else if (pop && head_taken) begin
                    TBL_WE        = 1'b1;
                    TBL_WR_STATE  = 1'b1;
                    TBL_WR_RETURN = fifo_ret[head];
                    TBL_WR_TAG    = head_tag;
                    TBL_WR_TARGET = head_target;
                end
            end
            default: next_state = INIT;
        endcase
        if (INV_ALL) begin
            next_state = INIT;
            next_sweep = '0;
        end
        if (RST)
            TBL_WE = 1'b0;
    end

    always_comb begin
        next_count = count;
        if (INV_ALL)
            next_count = '0;
        else if (push && !pop)
            next_count = count + (PW+1)'(1);
        else if (pop && !push)
            next_count = count - (PW+1)'(1);
        next_ready = (next_state == RUN) && (next_count != (PW+1)'(FIFO_DEPTH));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= INIT;
            sweep       <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            upd_ready_q <= 1'b0;
        end else begin
            state       <= next_state;
            sweep       <= next_sweep;
            count       <= next_count;
            upd_ready_q <= next_ready;
            if (INV_ALL) begin
                head <= '0;
                tail <= '0;
            end else begin
                if (push) tail <= tail + 1'b1;
                if (pop)  head <= head + 1'b1;
            end
        end
    end

    // Payload storage needs no reset; the pointers decide what is valid
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_pc[tail]     <= UPD_PC[ADDR_WIDTH-1:2];
            fifo_target[tail] <= UPD_TARGET;
            fifo_taken[tail]  <= UPD_TAKEN;
            fifo_ret[tail]    <= UPD_RETURN;
        end
    end

`ifdef BHT_PERF_CNT_EN
    logic [31:0] branch_cnt, mispred_cnt;
    logic        unused_inputs;

    always_ff @(posedge CLK) begin
        if (RST) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (push) begin
            branch_cnt <= branch_cnt + 32'd1;
            if (UPD_MISPRED)
                mispred_cnt <= mispred_cnt + 32'd1;
        end
    end

    assign BRANCH_CNT    = branch_cnt;
    assign MISPRED_CNT   = mispred_cnt;
    assign unused_inputs = ^UPD_PC[1:0];
`else
    logic unused_inputs;
    assign BRANCH_CNT    = '0;
    assign MISPRED_CNT   = '0;
    assign unused_inputs = ^{UPD_PC[1:0], UPD_MISPRED};
`endif

endmodule

// File: tb/tb_bht_update_sched.sv
// Directed bench for bht_update_sched: a behavioural table array plus a reference model feeding a write scoreboard.
// Counter expectations follow BHT_PERF_CNT_EN.
module tb_bht_update_sched;
    localparam int AW    = 39;
    localparam int DEPTH = 8;
    localparam int FD    = 4;
    localparam int H     = $clog2(DEPTH);
    localparam int TAG_W = AW - H - 2;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              PIPE_READY = 1'b1;
    logic              INV_ALL = 1'b0;
    logic              UPD_VALID = 1'b0;
    logic              UPD_READY;
    logic [AW-1:0]     UPD_PC = '0;
    logic [AW-1:0]     UPD_TARGET = '0;
    logic              UPD_TAKEN = 1'b0;
    logic              UPD_RETURN = 1'b0;
    logic              UPD_MISPRED = 1'b0;
    logic [H-1:0]      TBL_RD_IDX;
    logic              TBL_RD_STATE, TBL_RD_RETURN;
    logic [TAG_W-1:0]  TBL_RD_TAG;
    logic [AW-1:0]     TBL_RD_TARGET;
    logic [1:0]        TBL_RD_HIST;
    logic              TBL_WE;
    logic [H-1:0]      TBL_WR_IDX;
    logic              TBL_WR_STATE, TBL_WR_RETURN;
    logic [TAG_W-1:0]  TBL_WR_TAG;
    logic [AW-1:0]     TBL_WR_TARGET;
    logic [1:0]        TBL_WR_HIST;
    logic              INIT_BUSY;
    logic [31:0]       BRANCH_CNT, MISPRED_CNT;

    bht_update_sched #(.ADDR_WIDTH(AW), .HISTORY_DEPTH(DEPTH), .FIFO_DEPTH(FD)) dut (
        .CLK(CLK), .RST(RST), .PIPE_READY(PIPE_READY), .INV_ALL(INV_ALL),
        .UPD_VALID(UPD_VALID), .UPD_READY(UPD_READY), .UPD_PC(UPD_PC), .UPD_TARGET(UPD_TARGET),
        .UPD_TAKEN(UPD_TAKEN), .UPD_RETURN(UPD_RETURN), .UPD_MISPRED(UPD_MISPRED),
        .TBL_RD_IDX(TBL_RD_IDX), .TBL_RD_STATE(TBL_RD_STATE), .TBL_RD_RETURN(TBL_RD_RETURN),
        .TBL_RD_TAG(TBL_RD_TAG), .TBL_RD_TARGET(TBL_RD_TARGET), .TBL_RD_HIST(TBL_RD_HIST),
        .TBL_WE(TBL_WE), .TBL_WR_IDX(TBL_WR_IDX), .TBL_WR_STATE(TBL_WR_STATE),
        .TBL_WR_RETURN(TBL_WR_RETURN), .TBL_WR_TAG(TBL_WR_TAG), .TBL_WR_TARGET(TBL_WR_TARGET),
        .TBL_WR_HIST(TBL_WR_HIST), .INIT_BUSY(INIT_BUSY),
        .BRANCH_CNT(BRANCH_CNT), .MISPRED_CNT(MISPRED_CNT)
    );

    always #5 CLK = ~CLK;

    // Behavioural table storage: asynchronous read, write on the clock edge
    logic             tbl_state  [DEPTH];
    logic             tbl_ret    [DEPTH];
    logic [TAG_W-1:0] tbl_tag    [DEPTH];
    logic [AW-1:0]    tbl_target [DEPTH];
    logic [1:0]       tbl_hist   [DEPTH];

    always @(posedge CLK) begin
        if (TBL_WE) begin
            tbl_state[TBL_WR_IDX]  <= TBL_WR_STATE;
            tbl_ret[TBL_WR_IDX]    <= TBL_WR_RETURN;
            tbl_tag[TBL_WR_IDX]    <= TBL_WR_TAG;
            tbl_target[TBL_WR_IDX] <= TBL_WR_TARGET;
            tbl_hist[TBL_WR_IDX]   <= TBL_WR_HIST;
        end
    end

    assign TBL_RD_STATE  = tbl_state[TBL_RD_IDX];
    assign TBL_RD_RETURN = tbl_ret[TBL_RD_IDX];
    assign TBL_RD_TAG    = tbl_tag[TBL_RD_IDX];
    assign TBL_RD_TARGET = tbl_target[TBL_RD_IDX];
    assign TBL_RD_HIST   = tbl_hist[TBL_RD_IDX];

    typedef struct {
        logic [H-1:0]     idx;
        logic             st;
        logic [TAG_W-1:0] tag;
        logic [AW-1:0]    tgt;
        logic             ret;
        logic [1:0]       hist;
    } wr_t;

    wr_t exp_q[$];

    logic             m_state  [DEPTH];
    logic             m_ret    [DEPTH];
    logic [TAG_W-1:0] m_tag    [DEPTH];
    logic [AW-1:0]    m_target [DEPTH];
    logic [1:0]       m_hist   [DEPTH];

    int total_checks  = 0;
    int passed_checks = 0;
    int failed_checks = 0;
    int mdl_branches  = 0;
    int mdl_mispreds  = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total_checks++;
        assert (observed === expected) passed_checks++;
        else begin
            failed_checks++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [1:0] ref_hist(input logic [1:0] h, input logic taken);
        case ({taken, h})
            3'b100:  return 2'b01;
            3'b101:  return 2'b11;
            3'b110:  return 2'b11;
            3'b111:  return 2'b11;
            3'b011:  return 2'b10;
            3'b010:  return 2'b01;
            3'b001:  return 2'b00;
            default: return 2'b00;
        endcase
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_state[i]  = 1'b0;
            m_ret[i]    = 1'b0;
            m_tag[i]    = '0;
            m_target[i] = '0;
            m_hist[i]   = 2'b01;
        end
    endfunction

    // Updates apply in acceptance order, so the expected write is known at push time
    function automatic void model_apply(input logic [AW-1:0] pc, input logic [AW-1:0] tgt,
                                        input logic taken, input logic ret);
        logic [H-1:0]     idx;
        logic [TAG_W-1:0] tag;
        wr_t              e;
        idx = pc[H+1:2];
        tag = pc[AW-1:H+2];
        if (m_state[idx] && (m_tag[idx] == tag) && ((m_target[idx] == tgt) || !taken)) begin
            m_hist[idx] = ref_hist(m_hist[idx], taken);
            e = '{idx, 1'b1, m_tag[idx], m_target[idx], m_ret[idx], m_hist[idx]};
            exp_q.push_back(e);
        end else if (taken) begin
            m_state[idx]  = 1'b1;
            m_tag[idx]    = tag;
            m_target[idx] = tgt;
            m_ret[idx]    = ret;
            m_hist[idx]   = 2'b01;
            e = '{idx, 1'b1, tag, tgt, ret, 2'b01};
            exp_q.push_back(e);
        end
    endfunction

    // Every non-sweep table write must match the head of the scoreboard
    always @(negedge CLK) begin
        if (!RST && TBL_WE && !INIT_BUSY) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_write", TBL_WE, 1'b0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                checkOutput("wr_idx",    TBL_WR_IDX,    e.idx);
                checkOutput("wr_state",  TBL_WR_STATE,  e.st);
                checkOutput("wr_tag",    TBL_WR_TAG,    e.tag);
                checkOutput("wr_target", TBL_WR_TARGET, e.tgt);
                checkOutput("wr_return", TBL_WR_RETURN, e.ret);
                checkOutput("wr_hist",   TBL_WR_HIST,   e.hist);
            end
        end
    end

    // Called at posedge+1; drives one update for one cycle and returns whether it was taken
    task automatic applyStimulus(input logic [AW-1:0] pc, input logic [AW-1:0] tgt, input logic taken,
                                 input logic ret, input logic mis, output logic acc);
        UPD_VALID   = 1'b1;
        UPD_PC      = pc;
        UPD_TARGET  = tgt;
        UPD_TAKEN   = taken;
        UPD_RETURN  = ret;
        UPD_MISPRED = mis;
        acc = UPD_READY;
        if (acc) begin
            model_apply(pc, tgt, taken, ret);
            mdl_branches++;
            if (mis) mdl_mispreds++;
        end
        @(posedge CLK);
        #1;
        UPD_VALID = 1'b0;
    endtask

    task automatic checkSweep(input string tag);
        model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge CLK);
            checkOutput({tag, "_busy"},  INIT_BUSY,    1'b1);
            checkOutput({tag, "_we"},    TBL_WE,       1'b1);
            checkOutput({tag, "_idx"},   TBL_WR_IDX,   i[H-1:0]);
            checkOutput({tag, "_state"}, TBL_WR_STATE, 1'b0);
            checkOutput({tag, "_hist"},  TBL_WR_HIST,  2'b01);
            checkOutput({tag, "_ready"}, UPD_READY,    1'b0);
        end
        @(negedge CLK);
        checkOutput({tag, "_done_busy"},  INIT_BUSY, 1'b0);
        checkOutput({tag, "_done_ready"}, UPD_READY, 1'b1);
        checkOutput({tag, "_done_we"},    TBL_WE,    1'b0);
        @(posedge CLK);
        #1;
    endtask

    task automatic doReset();
        RST       = 1'b1;
        UPD_VALID = 1'b0;
        INV_ALL   = 1'b0;
        exp_q.delete();
        @(negedge CLK);
        checkOutput("rst_we", TBL_WE, 1'b0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        mdl_branches = 0;
        mdl_mispreds = 0;
        checkOutput("rst_branch_cnt",  BRANCH_CNT,  32'd0);
        checkOutput("rst_mispred_cnt", MISPRED_CNT, 32'd0);
        checkSweep("sweep");
    endtask

    task automatic waitDrain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge CLK);
            #1;
            n++;
        end
        checkOutput({tag, "_drain"}, exp_q.size(), 0);
    endtask

    initial begin
        logic acc;
        int   nacc;

        $display("[TB] start");
        doReset();

        // Miss with not-taken allocates nothing
        PIPE_READY = 1'b1;
        applyStimulus(39'h1000, 39'h2000, 1'b0, 1'b0, 1'b0, acc);
        @(negedge CLK);
        checkOutput("nt_miss_no_write", TBL_WE, 1'b0);
        @(posedge CLK);
        #1;

        // Allocate then train; the first write lands one edge after acceptance
        applyStimulus(39'h1000, 39'h2000, 1'b1, 1'b0, 1'b1, acc);
        checkOutput("alloc_latency", TBL_WE, 1'b1);
        applyStimulus(39'h1000, 39'h2000, 1'b1, 1'b0, 1'b0, acc);
        applyStimulus(39'h1000, 39'h2000, 1'b1, 1'b0, 1'b0, acc);
        applyStimulus(39'h1000, 39'h2000, 1'b0, 1'b0, 1'b1, acc);
        applyStimulus(39'h1000, 39'h3000, 1'b1, 1'b1, 1'b0, acc);
        waitDrain("train");
        checkOutput("train_tbl_hist",   tbl_hist[0],   2'b01);
        checkOutput("train_tbl_target", tbl_target[0], 39'h3000);

        // Stall: four slots fill, the fifth offer is refused
        PIPE_READY = 1'b0;
        nacc = 0;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) checkOutput("full_ready", UPD_READY, 1'b0);
            applyStimulus(39'h2000 + 39'(4 * k), 39'h5000 + 39'(16 * k), 1'b1, 1'b0, 1'(k == 1), acc);
            if (acc) nacc++;
        end
        checkOutput("stall_accepted", nacc, 4);
        @(negedge CLK);
        checkOutput("stall_no_write", TBL_WE, 1'b0);
        @(posedge CLK);
        #1;
        PIPE_READY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            checkOutput("drain_consecutive", TBL_WE, 1'b1);
            @(posedge CLK);
            #1;
        end
        @(negedge CLK);
        checkOutput("drain_idle_we",    TBL_WE,    1'b0);
        checkOutput("drain_idle_ready", UPD_READY, 1'b1);
        checkOutput("drain_scoreboard", exp_q.size(), 0);
        @(posedge CLK);
        #1;

        // INV_ALL with three pending updates discards them and re-sweeps
        PIPE_READY = 1'b0;
        for (int k = 0; k < 3; k++)
            applyStimulus(39'h3000 + 39'(4 * k), 39'h7000, 1'b1, 1'b0, 1'b0, acc);
        INV_ALL    = 1'b1;
        PIPE_READY = 1'b1;
        exp_q.delete();
        @(negedge CLK);
        checkOutput("inv_no_write", TBL_WE, 1'b0);
        @(posedge CLK);
        #1;
        INV_ALL = 1'b0;
        checkSweep("inv_sweep");

        // Counters after a fresh reset: ten updates, three mispredicted
        doReset();
        PIPE_READY = 1'b1;
        for (int k = 0; k < 10; k++)
            applyStimulus(39'h6000 + 39'(4 * k), 39'h8000 + 39'(k), 1'b1, 1'b0, 1'(k % 3 == 1), acc);
        waitDrain("cnt");
`ifdef BHT_PERF_CNT_EN
        checkOutput("branch_cnt",  BRANCH_CNT,  32'(mdl_branches));
        checkOutput("mispred_cnt", MISPRED_CNT, 32'(mdl_mispreds));
`else
        checkOutput("branch_cnt",  BRANCH_CNT,  32'd0);
        checkOutput("mispred_cnt", MISPRED_CNT, 32'd0);
`endif

        @(posedge CLK);
        #1;
        checkOutput("final_scoreboard", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
